// File: rtl/dmem_responder_if.sv
// Request/response bundle between the memory stage and the data-memory responder.
// The master drives a load/store request; the slave answers with ready, rd, rvalid and err.
interface dmem_responder_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              MemRead;
    logic              MemWrite;
    logic [2:0]        Funct3;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wd;
    logic              ready;
    logic [DATA_W-1:0] rd;
    logic              rvalid;
    logic              err;

    modport master (
        output MemRead, MemWrite, Funct3, addr, wd,
        input  ready, rd, rvalid, err
    );

    modport slave (
        input  MemRead, MemWrite, Funct3, addr, wd,
        output ready, rd, rvalid, err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store per handshake, commits it LATENCY cycles
// later and reports completion with a one-cycle rvalid pulse, flagging illegal accesses.
module dmem_responder #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    dmem_responder_if.slave   bus
);
    localparam int DEPTH = 1 << (ADDR_W - 2);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              req_rd;
    logic              req_wr;
    logic [2:0]        req_f3;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wd;
    logic [DATA_W-1:0] rd_q;
    logic              rvalid_q;
    logic              err_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              commit;
    logic              acc_err;
    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] load_val;
    logic [DATA_W-1:0] store_val;
    logic [3:0]        be;
    logic [7:0]        lane_byte;
    logic [15:0]       lane_half;

    assign accept = (state != BUSY) && (bus.MemRead || bus.MemWrite);
    assign commit = (state == BUSY) && (cnt == 4'd0);
    assign word   = mem[req_addr[ADDR_W-1:2]];

    assign bus.ready  = (state != BUSY);
    assign bus.rd     = rd_q;
    assign bus.rvalid = rvalid_q;
    assign bus.err    = err_q;

    // Decode the latched request: alignment/legality, load extension and store lane enables.
    always_comb begin
        acc_err   = req_rd && req_wr;
        lane_byte = word[{req_addr[1:0], 3'b000} +: 8];
        lane_half = req_addr[1] ? word[31:16] : word[15:0];
        load_val  = '0;
        store_val = '0;
        be        = 4'b0000;
        case (req_f3)
            3'b000: begin
                load_val  = {{24{lane_byte[7]}}, lane_byte};
                store_val = {4{req_wd[7:0]}};
                be        = 4'b0001 << req_addr[1:0];
            end
            3'b001: begin
                acc_err   = acc_err | req_addr[0];
                load_val  = {{16{lane_half[15]}}, lane_half};
                store_val = {2{req_wd[15:0]}};
                be        = req_addr[1] ? 4'b1100 : 4'b0011;
            end
            3'b010: begin
                acc_err   = acc_err | (req_addr[1:0] != 2'b00);
                load_val  = word;
                store_val = req_wd;
                be        = 4'b1111;
            end
            3'b100: begin
                acc_err  = acc_err | req_wr;
                load_val = {24'b0, lane_byte};
            end
            3'b101: begin
                acc_err  = acc_err | req_addr[0] | req_wr;
                load_val = {16'b0, lane_half};
            end
            default: acc_err = 1'b1;
        endcase
    end

    // Storage is deliberately not reset; only legal stores write, lane by lane.
    always_ff @(posedge clk) begin
        if (commit && req_wr && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[req_addr[ADDR_W-1:2]][8*i +: 8] <= store_val[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            req_rd   <= 1'b0;
            req_wr   <= 1'b0;
            req_f3   <= 3'b000;
            req_addr <= '0;
            req_wd   <= '0;
            rd_q     <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE, RESP: begin
                    rvalid_q <= 1'b0;
                    err_q    <= 1'b0;
                    if (accept) begin
                        req_rd   <= bus.MemRead;
                        req_wr   <= bus.MemWrite;
                        req_f3   <= bus.Funct3;
                        req_addr <= bus.addr;
                        req_wd   <= bus.wd;
                        cnt      <= 4'(LATENCY - 1);
                        state    <= BUSY;
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state    <= RESP;
                        rvalid_q <= 1'b1;
                        err_q    <= acc_err;
                        rd_q     <= (!req_wr && !acc_err) ? load_val : '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: stimulus pushes expected responses,
// a negedge monitor pops and compares them whenever rvalid is seen.
module tb_dmem_responder;
    localparam int ADDR_W  = 9;
    localparam int LATENCY = 2;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;
    exp_t sb[$];

    dmem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(32)) bus ();

    dmem_responder #(.ADDR_W(ADDR_W), .DATA_W(32), .LATENCY(LATENCY)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Response monitor: every rvalid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && bus.rvalid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_rvalid: got rvalid=1 rd=0x%08h expected no response", bus.rd);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_output("resp_rd", bus.rd, e.rd);
                check_output("resp_err", {31'b0, bus.err}, {31'b0, e.err});
                check_output("resp_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic apply_stimulus(input logic r, input logic w, input logic [2:0] f3,
                                  input logic [ADDR_W-1:0] a, input logic [31:0] d,
                                  input logic [31:0] exp_rd, input logic exp_err);
        int   n;
        int   busy;
        exp_t e;
        bus.MemRead  = r;
        bus.MemWrite = w;
        bus.Funct3   = f3;
        bus.addr     = a;
        bus.wd       = d;
        n = 0;
        @(negedge clk);
        while (!bus.ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!bus.ready) begin
            check_output("accept_timeout", 32'd0, 32'd1);
            bus.MemRead  = 1'b0;
            bus.MemWrite = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e.rd  = exp_rd;
        e.err = exp_err;
        e.cyc = cyc + LATENCY;
        sb.push_back(e);
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        busy = 0;
        @(negedge clk);
        while (!bus.ready && busy < 20) begin
            busy++;
            @(negedge clk);
        end
        check_output("ready_low_cycles", busy, LATENCY);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            n++;
            @(posedge clk);
        end
        if (sb.size() != 0) begin
            check_output("drain_timeout", sb.size(), 32'd0);
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int   n;
        exp_t e;
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.Funct3   = 3'b000;
        bus.addr     = '0;
        bus.wd       = '0;
        repeat (3) @(negedge clk);
        check_output("reset_ready", {31'b0, bus.ready}, 32'd1);
        check_output("reset_rvalid", {31'b0, bus.rvalid}, 32'd0);
        check_output("reset_err", {31'b0, bus.err}, 32'd0);
        check_output("reset_rd", bus.rd, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Basic word store/load plus sub-word loads
        apply_stimulus(1'b0, 1'b1, 3'b010, 9'h020, 32'h00000000, 32'h0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 3'b010, 9'h010, 32'hDEADBEEF, 32'h0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 3'b010, 9'h010, 32'h0, 32'hDEADBEEF, 1'b0);
        apply_stimulus(1'b1, 1'b0, 3'b000, 9'h013, 32'h0, 32'hFFFFFFDE, 1'b0);
        apply_stimulus(1'b1, 1'b0, 3'b100, 9'h013, 32'h0, 32'h000000DE, 1'b0);
        apply_stimulus(1'b1, 1'b0, 3'b001, 9'h012, 32'h0, 32'hFFFFDEAD, 1'b0);
        apply_stimulus(1'b1, 1'b0, 3'b101, 9'h010, 32'h0, 32'h0000BEEF, 1'b0);

        // Illegal accesses must flag err, return zero and leave memory alone
        apply_stimulus(1'b1, 1'b0, 3'b010, 9'h012, 32'h0, 32'h0, 1'b1);
        apply_stimulus(1'b0, 1'b1, 3'b001, 9'h011, 32'h00001234, 32'h0, 1'b1);
        apply_stimulus(1'b1, 1'b1, 3'b010, 9'h010, 32'h00000000, 32'h0, 1'b1);
        apply_stimulus(1'b0, 1'b1, 3'b100, 9'h010, 32'h00000000, 32'h0, 1'b1);
        apply_stimulus(1'b1, 1'b0, 3'b011, 9'h010, 32'h0, 32'h0, 1'b1);
        apply_stimulus(1'b1, 1'b0, 3'b010, 9'h010, 32'h0, 32'hDEADBEEF, 1'b0);

        // Byte and halfword stores merge into the existing word
        apply_stimulus(1'b0, 1'b1, 3'b000, 9'h011, 32'h00000055, 32'h0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 3'b010, 9'h010, 32'h0, 32'hDEAD55EF, 1'b0);
        apply_stimulus(1'b0, 1'b1, 3'b001, 9'h012, 32'h0000CAFE, 32'h0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 3'b010, 9'h010, 32'h0, 32'hCAFE55EF, 1'b0);
        wait_idle();

        // Back-to-back: request held high, fields changed while BUSY
        bus.MemRead = 1'b1;
        bus.Funct3  = 3'b010;
        bus.addr    = 9'h010;
        @(negedge clk);
        check_output("b2b_ready_first", {31'b0, bus.ready}, 32'd1);
        @(posedge clk);
        #1;
        n     = cyc;
        e.rd  = 32'hCAFE55EF;
        e.err = 1'b0;
        e.cyc = n + LATENCY;
        sb.push_back(e);
        bus.Funct3 = 3'b000;
        bus.addr   = 9'h013;
        repeat (LATENCY + 1) @(posedge clk);
        #1;
        e.rd  = 32'hFFFFFFCA;
        e.err = 1'b0;
        e.cyc = n + 2 * (LATENCY + 1) - 1;
        sb.push_back(e);
        bus.MemRead = 1'b0;
        wait_idle();

        // Reset mid-store abandons the write
        bus.MemWrite = 1'b1;
        bus.Funct3   = 3'b010;
        bus.addr     = 9'h020;
        bus.wd       = 32'h11111111;
        @(negedge clk);
        @(posedge clk);
        #1;
        bus.MemWrite = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_output("midreset_rvalid", {31'b0, bus.rvalid}, 32'd0);
        check_output("midreset_err", {31'b0, bus.err}, 32'd0);
        check_output("midreset_rd", bus.rd, 32'd0);
        check_output("midreset_ready", {31'b0, bus.ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        apply_stimulus(1'b1, 1'b0, 3'b010, 9'h020, 32'h0, 32'h00000000, 1'b0);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
